if_stage_buf: RTL

IF_STAGE_BUF -- requirements
Module: if_stage_buf

---
 rtl/if_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 72 +++++++
 rtl/if_stage_buf.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch stage
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;
  localparam logic [1:0]  SIZE_WORD        = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used for fetch tags and fetched instructions
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop, empty, full;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AW+1)'(DEPTH));
    do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_data;
        wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign pop_data = mem_q[rptr_q];
  assign count    = count_q;

endmodule

// File: rtl/if_stage_buf.sv
// rtl/if_stage_buf.sv - fetch stage: SRAM request pipeline feeding an instruction buffer
module if_stage_buf
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adef,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic          started_q, started_d;
  logic          stall_q, stall_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] tag_count, buf_count;
  logic [31:0]   tag_head;
  fetch_entry_t  buf_in, buf_head;
  logic [CW:0]   occupancy;
  logic          fetch_ok, aligned, room, hs, rsp, rsp_keep, adef_push;
  logic          buf_push, buf_pop, buf_full, buf_empty;

  always_comb begin
    occupancy = {1'b0, inflight_q} + {1'b0, buf_count};
    room      = occupancy < (CW+1)'(DEPTH);
    aligned   = (pc_q[1:0] == 2'b00);
    buf_full  = (buf_count == CW'(DEPTH));
    buf_empty = (buf_count == '0);
    fetch_ok  = rst & started_q & ~br_taken & ~stall_q;
    inst_sram_req = fetch_ok & aligned & room;
    hs        = inst_sram_req & inst_sram_addr_ok;
    rsp       = inst_sram_data_ok & (inflight_q != '0);
    rsp_keep  = rsp & (discard_q == '0) & ~br_taken;
    adef_push = fetch_ok & ~aligned & ~buf_full & ~rsp_keep;
    buf_push  = rsp_keep | adef_push;
    out_valid = rst & ~buf_empty;
    buf_pop   = out_valid & out_ready;

    buf_in = '{pc: pc_q, inst: 32'h0, adef: 1'b1};
    if (rsp_keep) begin
      buf_in = '{pc: tag_head, inst: inst_sram_rdata, adef: 1'b0};
    end

    started_d = 1'b1;
    pc_d      = pc_q;
    stall_d   = stall_q;
    if (br_taken) begin
      pc_d    = br_target;
      stall_d = 1'b0;
    end else begin
      if (hs)        pc_d    = pc_q + 32'd4;
      if (adef_push) stall_d = 1'b1;
    end

    case ({hs, rsp})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    // Every outstanding response predates the redirect, so after a flush the
    // drop count is exactly what remains in flight; this also bounds it by DEPTH.
    if (br_taken) begin
      discard_d = inflight_q - CW'(rsp);
    end else begin
      discard_d = discard_q - CW'(rsp && (discard_q != '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      started_q  <= 1'b0;
      stall_q    <= 1'b0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      started_q  <= started_d;
      stall_q    <= stall_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (hs),
    .push_data (pc_q),
    .pop       (rsp),
    .pop_data  (tag_head),
    .count     (tag_count)
  );

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (br_taken),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .pop_data  (buf_head),
    .count     (buf_count)
  );

  assert property (@(posedge clk) disable iff (!rst) !(inst_sram_data_ok && inflight_q == '0));
  assert property (@(posedge clk) disable iff (!rst) tag_count == inflight_q);

  assign out_pc          = buf_head.pc;
  assign out_inst        = buf_head.inst;
  assign out_adef        = buf_head.adef;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = SIZE_WORD;
  assign inst_sram_wstrb = 4'b0;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'h0;

endmodule
